nf10_id_fetch: RTL and testbench

NF10_ID_FETCH -- requirements
Module: nf10_id_fetch

---
 rtl/nf10_id_fetch.sv | 216 +++++++++++++++++++++
 tb/tb_nf10_id_fetch.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_id_fetch.sv
`default_nettype none
// ============================================================================
// Module      : nf10_id_fetch
// Description : AXI4-Lite read master that fetches the identifier register
//               bank (date, time, project, tag, board) one word at a time.
//               It reports busy/done/error and records where a fetch failed.
// Revision    : 1.0 - initial release
// ============================================================================
module nf10_id_fetch #(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_ID_BASEADDR      = '0,
    parameter int unsigned                   NUM_WORDS          = 5,
    parameter int unsigned                   C_TIMEOUT_CYCLES   = 255,
    parameter bit                            C_AUTO_START       = 1'b1
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic                          M_AXI_AWVALID,
    output logic                          M_AXI_WVALID,
    output logic                          M_AXI_BREADY,
    output logic [31:0]                   id_date,
    output logic [31:0]                   id_time,
    output logic [31:0]                   id_project,
    output logic [31:0]                   id_tag,
    output logic [31:0]                   id_board,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [2:0]                    err_index,
    output logic [1:0]                    err_code
);

    // Unsupported configurations are rejected at elaboration time.
    generate
        if (C_M_AXI_DATA_WIDTH != 32 || NUM_WORDS < 1 || NUM_WORDS > 5 ||
            C_TIMEOUT_CYCLES < 1) begin : g_bad_config
            $error("nf10_id_fetch: unsupported parameter combination");
        end
    endgenerate

    // The counter only has to reach C_TIMEOUT_CYCLES-1.
    localparam int unsigned WAIT_W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(C_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]        C_IDX_LAST  = 3'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                        state_q,      state_d;
    logic [2:0]                    idx_q,        idx_d;
    logic [WAIT_W-1:0]             wait_q,       wait_d;
    logic                          auto_start_q, auto_start_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q,     araddr_d;
    logic                          arvalid_q,    arvalid_d;
    logic                          rready_q,     rready_d;
    logic                          busy_q,       busy_d;
    logic                          done_q,       done_d;
    logic                          error_q,      error_d;
    logic [2:0]                    err_index_q,  err_index_d;
    logic [1:0]                    err_code_q,   err_code_d;
    logic [4:0][31:0]              word_q,       word_d;
    logic                          launch;

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr(input logic [2:0] i);
        return C_ID_BASEADDR + C_M_AXI_ADDR_WIDTH'({i, 2'b00});
    endfunction

    // Sequencer: next state, index, wait counter, captured words and status.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        auto_start_d = auto_start_q;
        araddr_d     = araddr_q;
        err_index_d  = err_index_q;
        err_code_d   = err_code_q;
        word_d       = word_q;
        launch       = 1'b0;

        case (state_q)
            S_IDLE: launch = start | auto_start_q;
            S_DONE,
            S_ERR:  launch = start;
            S_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_DATA;
                    wait_d  = '0;
                end else if (wait_q == C_WAIT_LAST) begin
                    // A stalled address phase is fatal; ARVALID drops with the state.
                    state_d     = S_ERR;
                    err_index_d = idx_q;
                    err_code_d  = 2'b01;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DATA: begin
                if (M_AXI_RVALID) begin
                    wait_d = '0;
                    if (M_AXI_RRESP == 2'b00) begin
                        for (int i = 0; i < 5; i++) begin
                            if (idx_q == 3'(i)) begin
                                word_d[i] = M_AXI_RDATA;
                            end
                        end
                        if (idx_q == C_IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d    = idx_q + 3'd1;
                            araddr_d = word_addr(idx_q + 3'd1);
                            state_d  = S_ADDR;
                        end
                    end else begin
                        // Slave error: the beat is discarded.
                        state_d     = S_ERR;
                        err_index_d = idx_q;
                        err_code_d  = M_AXI_RRESP;
                    end
                end else if (wait_q == C_WAIT_LAST) begin
                    state_d     = S_ERR;
                    err_index_d = idx_q;
                    err_code_d  = 2'b01;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Starting (or restarting) a fetch always begins at word 0 with clean status.
        if (launch) begin
            state_d      = S_ADDR;
            idx_d        = 3'd0;
            wait_d       = '0;
            auto_start_d = 1'b0;
            araddr_d     = word_addr(3'd0);
            err_index_d  = 3'd0;
            err_code_d   = 2'b00;
        end

        // Outputs are registered copies of what the next state implies.
        arvalid_d = (state_d == S_ADDR);
        rready_d  = (state_d == S_DATA);
        busy_d    = (state_d == S_ADDR) || (state_d == S_DATA);
        done_d    = (state_d == S_DONE);
        error_d   = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            wait_q       <= '0;
            auto_start_q <= C_AUTO_START;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_index_q  <= 3'd0;
            err_code_q   <= 2'b00;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            auto_start_q <= auto_start_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_index_q  <= err_index_d;
            err_code_q   <= err_code_d;
            word_q       <= word_d;
        end
    end

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b1;

    assign id_date    = word_q[0];
    assign id_time    = word_q[1];
    assign id_project = word_q[2];
    assign id_tag     = word_q[3];
    assign id_board   = word_q[4];

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;
    assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_nf10_id_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_nf10_id_fetch
// Description : Directed bench for nf10_id_fetch with a configurable
//               AXI4-Lite read slave (delays, error responses, stalls).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nf10_id_fetch;

    localparam logic [31:0] BASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic        M_AXI_AWVALID;
    logic        M_AXI_WVALID;
    logic        M_AXI_BREADY;
    logic [31:0] id_date, id_time, id_project, id_tag, id_board;
    logic        busy, done, error;
    logic [2:0]  err_index;
    logic [1:0]  err_code;

    nf10_id_fetch #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_ID_BASEADDR      (BASE),
        .NUM_WORDS          (5),
        .C_TIMEOUT_CYCLES   (255),
        .C_AUTO_START       (1'b1)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .start         (start),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .id_date       (id_date),
        .id_time       (id_time),
        .id_project    (id_project),
        .id_tag        (id_tag),
        .id_board      (id_board),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_index     (err_index),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave configuration and log
    // ------------------------------------------------------------------
    int          ar_delay  = 0;
    int          r_delay   = 0;
    int          err_word  = -1;
    logic [1:0]  err_resp  = 2'b00;
    int          no_r_word = -1;
    bit          no_ar     = 1'b0;
    logic [31:0] tbl [5];
    int          ar_n      = 0;
    logic [31:0] ar_log [16];
    int          unstable  = 0;

    int          ar_cnt = 0, r_cnt = 0, cur_word = 0;
    bit          r_pend = 1'b0, rst_e = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
    bit          arv_s = 1'b0, rr_s = 1'b0;
    logic [31:0] ara_s = '0;

    // Reactive read slave: handshakes judged at the edge, drives updated #1 later.
    initial begin
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = 32'h0;
        M_AXI_RRESP   = 2'b00;
        forever begin
            @(posedge clk);
            rst_e = rst;
            ar_hs = arv_s && M_AXI_ARREADY;
            r_hs  = rr_s && M_AXI_RVALID;
            #1;
            if (rst_e) begin
                r_pend        = 1'b0;
                ar_cnt        = 0;
                r_cnt         = 0;
                M_AXI_ARREADY = 1'b0;
                M_AXI_RVALID  = 1'b0;
                M_AXI_RDATA   = 32'h0;
                M_AXI_RRESP   = 2'b00;
            end else begin
                if (arv_s && !ar_hs && M_AXI_ARVALID && (M_AXI_ARADDR !== ara_s))
                    unstable++;
                if (ar_hs) begin
                    cur_word = int'((ara_s - BASE) >> 2);
                    if (ar_n < 16) ar_log[ar_n] = ara_s;
                    ar_n++;
                    r_pend = 1'b1;
                    r_cnt  = 0;
                    ar_cnt = 0;
                end
                if (r_hs) r_pend = 1'b0;
                if (M_AXI_ARVALID && !no_ar) begin
                    M_AXI_ARREADY = (ar_cnt >= ar_delay);
                    ar_cnt++;
                end else begin
                    M_AXI_ARREADY = 1'b0;
                end
                if (r_pend && (cur_word != no_r_word)) begin
                    M_AXI_RVALID = (r_cnt >= r_delay);
                    r_cnt++;
                    M_AXI_RDATA  = (cur_word >= 0 && cur_word < 5) ? tbl[cur_word] : 32'hBAD0_0000;
                    M_AXI_RRESP  = (cur_word == err_word) ? err_resp : 2'b00;
                end else begin
                    M_AXI_RVALID = 1'b0;
                    M_AXI_RDATA  = 32'hDEAD_BEEF;
                    M_AXI_RRESP  = 2'b00;
                end
            end
            arv_s = M_AXI_ARVALID;
            ara_s = M_AXI_ARADDR;
            rr_s  = M_AXI_RREADY;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_flag(input int max_cyc, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            step(1);
            if (done || error) begin
                at_cyc = cyc;
                return;
            end
        end
        check_val("wait_bound_expired", 32'd0, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_busy"},    busy,          1'b0);
        check_val({tag, "_done"},    done,          1'b0);
        check_val({tag, "_error"},   error,         1'b0);
        check_val({tag, "_arvalid"}, M_AXI_ARVALID, 1'b0);
        check_val({tag, "_rready"},  M_AXI_RREADY,  1'b0);
        check_val({tag, "_araddr"},  M_AXI_ARADDR,  32'h0);
        check_val({tag, "_eidx"},    err_index,     3'd0);
        check_val({tag, "_ecode"},   err_code,      2'b00);
        check_val({tag, "_date"},    id_date,       32'h0);
        check_val({tag, "_time"},    id_time,       32'h0);
        check_val({tag, "_proj"},    id_project,    32'h0);
        check_val({tag, "_tag"},     id_tag,        32'h0);
        check_val({tag, "_board"},   id_board,      32'h0);
    endtask

    task automatic load_tbl_a();
        tbl[0] = 32'h20130415;
        tbl[1] = 32'h00143000;
        tbl[2] = 32'h0000CAFE;
        tbl[3] = 32'h00000001;
        tbl[4] = 32'h00000002;
    endtask

    task automatic check_ids_a(input string tag);
        check_val({tag, "_date"},  id_date,    32'h20130415);
        check_val({tag, "_time"},  id_time,    32'h00143000);
        check_val({tag, "_proj"},  id_project, 32'h0000CAFE);
        check_val({tag, "_tag"},   id_tag,     32'h00000001);
        check_val({tag, "_board"}, id_board,   32'h00000002);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int  t0, tc;
    bit  found;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        load_tbl_a();
        step(3);
        check_reset("rst0");
        check_val("rst0_awvalid", M_AXI_AWVALID, 1'b0);
        check_val("rst0_wvalid",  M_AXI_WVALID,  1'b0);
        check_val("rst0_bready",  M_AXI_BREADY,  1'b1);

        // T1: auto-start, zero-wait slave
        ar_n = 0;
        rst  = 1'b0;
        t0   = cyc;
        step(1);
        check_val("t1_busy_c1",    busy,          1'b1);
        check_val("t1_arvalid_c1", M_AXI_ARVALID, 1'b1);
        check_val("t1_araddr_c1",  M_AXI_ARADDR,  BASE);
        wait_flag(100, tc);
        check_val("t1_latency", tc - t0, 32'd11);
        check_val("t1_done",  done,  1'b1);
        check_val("t1_error", error, 1'b0);
        check_val("t1_busy",  busy,  1'b0);
        check_ids_a("t1");
        check_val("t1_ar_n",  ar_n,      32'd5);
        check_val("t1_addr0", ar_log[0], BASE + 32'h0);
        check_val("t1_addr1", ar_log[1], BASE + 32'h4);
        check_val("t1_addr2", ar_log[2], BASE + 32'h8);
        check_val("t1_addr3", ar_log[3], BASE + 32'hC);
        check_val("t1_addr4", ar_log[4], BASE + 32'h10);

        // T2: ARREADY delay 3, RVALID delay 7
        ar_delay = 3;
        r_delay  = 7;
        rst = 1'b1;
        step(2);
        ar_n     = 0;
        unstable = 0;
        rst = 1'b0;
        t0  = cyc;
        wait_flag(200, tc);
        check_val("t2_latency", tc - t0, 32'd61);
        check_val("t2_done",  done,  1'b1);
        check_val("t2_error", error, 1'b0);
        check_ids_a("t2");
        check_val("t2_araddr_stable", unstable, 32'd0);
        check_val("t2_addr4", ar_log[4], BASE + 32'h10);

        // T3: restart from DONE with new slave contents
        ar_delay = 0;
        r_delay  = 0;
        tbl[0] = 32'h20240101;
        tbl[1] = 32'h00235959;
        tbl[2] = 32'h0000BEEF;
        tbl[3] = 32'h00000007;
        tbl[4] = 32'h00000003;
        start = 1'b1;
        t0    = cyc;
        step(1);
        start = 1'b0;
        check_val("t3_done_drop", done, 1'b0);
        check_val("t3_busy",      busy, 1'b1);
        wait_flag(100, tc);
        check_val("t3_latency", tc - t0, 32'd11);
        check_val("t3_done",  done,       1'b1);
        check_val("t3_date",  id_date,    32'h20240101);
        check_val("t3_time",  id_time,    32'h00235959);
        check_val("t3_proj",  id_project, 32'h0000BEEF);
        check_val("t3_tag",   id_tag,     32'h00000007);
        check_val("t3_board", id_board,   32'h00000003);

        // T4: SLVERR on word 2
        err_word = 2;
        err_resp = 2'b10;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        t0  = cyc;
        wait_flag(100, tc);
        check_val("t4_latency", tc - t0, 32'd7);
        check_val("t4_error", error,      1'b1);
        check_val("t4_done",  done,       1'b0);
        check_val("t4_busy",  busy,       1'b0);
        check_val("t4_eidx",  err_index,  3'd2);
        check_val("t4_ecode", err_code,   2'b10);
        check_val("t4_date",  id_date,    32'h20240101);
        check_val("t4_time",  id_time,    32'h00235959);
        check_val("t4_proj",  id_project, 32'h0);
        check_val("t4_tag",   id_tag,     32'h0);
        err_word = -1;
        err_resp = 2'b00;

        // T5: no RVALID on word 0 -> data-phase timeout
        no_r_word = 0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        t0  = cyc;
        wait_flag(400, tc);
        check_val("t5_latency", tc - t0, 32'd257);
        check_val("t5_error",  error,        1'b1);
        check_val("t5_ecode",  err_code,     2'b01);
        check_val("t5_eidx",   err_index,    3'd0);
        check_val("t5_busy",   busy,         1'b0);
        check_val("t5_rready", M_AXI_RREADY, 1'b0);

        // T5b: restart from ERR, slave never accepts the address; the stale
        // R beat left over from T5 is presented outside the data phase.
        no_r_word = -1;
        no_ar     = 1'b1;
        start = 1'b1;
        t0    = cyc;
        step(1);
        start = 1'b0;
        check_val("t5b_error_clr", error, 1'b0);
        wait_flag(400, tc);
        check_val("t5b_latency", tc - t0, 32'd256);
        check_val("t5b_error",   error,         1'b1);
        check_val("t5b_ecode",   err_code,      2'b01);
        check_val("t5b_eidx",    err_index,     3'd0);
        check_val("t5b_arvalid", M_AXI_ARVALID, 1'b0);
        check_val("t5b_date",    id_date,       32'h0);
        no_ar = 1'b0;

        // T6: start while busy is ignored; reset during word 3 data phase
        load_tbl_a();
        r_delay = 4;
        rst = 1'b1;
        step(2);
        ar_n = 0;
        rst  = 1'b0;
        t0   = cyc;
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (ar_n == 4 && M_AXI_RVALID) found = 1'b1;
        end
        check_val("t6_reach_word3", found, 1'b1);
        rst = 1'b1;
        step(2);
        check_reset("t6");
        check_val("t6_addr1", ar_log[1], BASE + 32'h4);
        check_val("t6_addr3", ar_log[3], BASE + 32'hC);
        r_delay = 0;
        ar_n    = 0;
        rst = 1'b0;
        t0  = cyc;
        wait_flag(100, tc);
        check_val("t6_latency", tc - t0, 32'd11);
        check_val("t6_done",  done,  1'b1);
        check_val("t6_error", error, 1'b0);
        check_ids_a("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
